boom_step_counter: RTL and testbench

//   Game-count source for the "boom" display path. Produces the 5-bit count that feeds

---
 rtl/boom_pkg.sv | 14 +
 rtl/btn_debounce.sv | 57 +++++
 rtl/boom_step_counter.sv | 145 ++++++++++++++
 tb/tb_boom_step_counter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boom_pkg.sv
// Shared constants for the boom display path.
// State encoding, default width, boom divisor.
package boom_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int BOOM_DIV  = 6;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, stable-level debounce,
// one-cycle press pulse on accepted 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // any cycle where synced level matches restarts the streak
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/boom_step_counter.sv
// Game-count source: manual steps or prescaled auto ticks,
// dwelling on boom values reported back by the comparator.
module boom_step_counter
  import boom_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int MAX_COUNT    = 31,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int TICK_DIV     = 25_000_000,
  parameter int BOOM_HOLD    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             boom_led,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             mode_auto,
  output logic             holding
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(BOOM_HOLD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BOOM_HOLD - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_COUNT);

  logic step_press;
  logic mode_press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_step),
    .press   (step_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .press   (mode_press)
  );

  state_e           state_q;
  state_e           state_d;
  logic [TW-1:0]    tick_q;
  logic [TW-1:0]    tick_d;
  logic [HW-1:0]    hold_q;
  logic [HW-1:0]    hold_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             step_pulse_q;
  logic             step_pulse_d;
  logic             inc;
  logic             tick_term;

  assign tick_term = (tick_q == TICK_LAST);

  // mode press always takes priority over step and tick
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    inc     = 1'b0;
    unique case (state_q)
      ST_MANUAL: begin
        tick_d = '0;
        hold_d = '0;
        if (mode_press) begin
          state_d = ST_AUTO;
        end else if (step_press) begin
          inc = 1'b1;
        end
      end
      ST_AUTO: begin
        tick_d = tick_term ? '0 : tick_q + TW'(1);
        if (mode_press) begin
          state_d = ST_MANUAL;
          tick_d  = '0;
          hold_d  = '0;
        end else if (tick_term) begin
          if (boom_led) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            inc = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        tick_d = tick_term ? '0 : tick_q + TW'(1);
        if (mode_press) begin
          state_d = ST_MANUAL;
          tick_d  = '0;
          hold_d  = '0;
        end else if (tick_term) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_AUTO;
            hold_d  = '0;
            inc     = 1'b1;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: begin
        state_d = ST_MANUAL;
        tick_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    count_d      = count_q;
    step_pulse_d = inc;
    if (inc) begin
      count_d = (count_q == CNT_MAX) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_MANUAL;
      tick_q       <= '0;
      hold_q       <= '0;
      count_q      <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign count      = count_q;
  assign step_pulse = step_pulse_q;
  assign mode_auto  = (state_q != ST_MANUAL);
  assign holding    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_boom_step_counter.sv
// Bench for boom_step_counter: history-window debounce model,
// tick/dwell auto model, per-cycle compare plus literal pins.
module tb_boom_step_counter;
  import boom_pkg::*;

  localparam int W    = 5;
  localparam int MAXC = 31;
  localparam int DC   = 4;
  localparam int TD   = 8;
  localparam int BH   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_step = 1'b0;
  logic         btn_mode = 1'b0;
  logic         boom_led;
  logic [W-1:0] count;
  logic         step_pulse;
  logic         mode_auto;
  logic         holding;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // comparator stand-in
  assign boom_led = (int'(count) % BOOM_DIV) == 0;

  always #5 clk = ~clk;

  boom_step_counter #(
    .WIDTH        (W),
    .MAX_COUNT    (MAXC),
    .DEBOUNCE_CYC (DC),
    .TICK_DIV     (TD),
    .BOOM_HOLD    (BH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_step   (btn_step),
    .btn_mode   (btn_mode),
    .boom_led   (boom_led),
    .count      (count),
    .step_pulse (step_pulse),
    .mode_auto  (mode_auto),
    .holding    (holding)
  );

  int m_count = 0;
  bit m_auto = 1'b0;
  int m_dwell = 0;
  int m_el = 0;
  bit m_pulse = 1'b0;
  bit hs[DC+1];
  bit hm[DC+1];
  bit db_s = 1'b0;
  bit db_m = 1'b0;
  bit pr_s = 1'b0;
  bit pr_m = 1'b0;

  // h[1..DC] are the synced samples of the last DC cycles
  function automatic bit streak(input bit h[DC+1], input bit lvl);
    for (int i = 1; i <= DC; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int c;
    int dw;
    int el;
    bit au;
    bit pu;
    bit ns;
    bit nm;
    c  = m_count;
    dw = m_dwell;
    el = m_el;
    au = m_auto;
    pu = 1'b0;
    if (rst) begin
      m_count <= 0;
      m_auto  <= 1'b0;
      m_dwell <= 0;
      m_el    <= 0;
      m_pulse <= 1'b0;
      db_s    <= 1'b0;
      db_m    <= 1'b0;
      pr_s    <= 1'b0;
      pr_m    <= 1'b0;
      for (int i = 0; i <= DC; i++) begin
        hs[i] <= 1'b0;
        hm[i] <= 1'b0;
      end
    end else begin
      if (!au) begin
        if (pr_m) begin
          au = 1'b1;
          el = 0;
          dw = 0;
        end else if (pr_s) begin
          pu = 1'b1;
        end
      end else begin
        el++;
        if (pr_m) begin
          au = 1'b0;
          el = 0;
          dw = 0;
        end else if (el % TD == 0) begin
          if ((c % BOOM_DIV == 0) && dw < BH) begin
            dw++;
          end else begin
            pu = 1'b1;
            dw = 0;
          end
        end
      end
      if (pu) c = (c == MAXC) ? 0 : c + 1;
      ns = streak(hs, db_s);
      nm = streak(hm, db_m);
      pr_s <= ns && !db_s;
      pr_m <= nm && !db_m;
      if (ns) db_s <= !db_s;
      if (nm) db_m <= !db_m;
      hs[0] <= btn_step;
      hm[0] <= btn_mode;
      for (int i = 1; i <= DC; i++) begin
        hs[i] <= hs[i-1];
        hm[i] <= hm[i-1];
      end
      m_count <= c;
      m_auto  <= au;
      m_dwell <= dw;
      m_el    <= el;
      m_pulse <= pu;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic press(input bit s, input bit m);
    btn_step = s;
    btn_mode = m;
    cyc(8);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    cyc(8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    int n;
    int n6;
    int nh;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          total++;
          if (step_pulse) pulses++;
          if (count !== W'(m_count) || step_pulse !== m_pulse ||
              mode_auto !== m_auto ||
              holding !== (m_auto && m_dwell > 0)) begin
            bad++;
            $display("FAIL cycle t=%0t got c=%0d p=%b a=%b h=%b want c=%0d p=%b a=%b h=%b",
                     $time, count, step_pulse, mode_auto, holding,
                     m_count, m_pulse, m_auto, (m_auto && m_dwell > 0));
          end
        end
      end
    join_none

    do_reset();
    chk_en = 1'b1;
    chk("init_count", int'(count), 0);
    chk("init_auto", int'(mode_auto), 0);

    // bounce shorter than the debounce window, then a clean hold
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      btn_step = ~btn_step;
      cyc(2);
    end
    btn_step = 1'b1;
    cyc(12);
    btn_step = 1'b0;
    cyc(12);
    chk("bounce_count", int'(count), 1);
    chk("bounce_pulses", pulses - p0, 1);

    // full wrap
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 31; i++) press(1'b1, 1'b0);
    chk("wrap_31", int'(count), 31);
    press(1'b1, 1'b0);
    chk("wrap_0", int'(count), 0);
    chk("wrap_pulses", pulses - p0, 32);

    // auto dwell on 6
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    chk("pre_auto", int'(count), 5);
    btn_mode = 1'b1;
    cyc(8);
    btn_mode = 1'b0;
    n = 0;
    while (count != 5'd6 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("reach_6", int'(count), 6);
    n6 = 0;
    nh = 0;
    for (int i = 0; i < 60 && count == 5'd6; i++) begin
      if (holding) nh++;
      n6++;
      btn_step = (i >= 3 && i < 13);
      cyc(1);
    end
    btn_step = 1'b0;
    chk("dwell6_cycles", n6, 24);
    chk("dwell6_hold", nh, 16);
    chk("after_dwell", int'(count), 7);
    chk("still_auto", int'(mode_auto), 1);
    press(1'b0, 1'b1);

    // simultaneous step + mode
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    btn_step = 1'b1;
    btn_mode = 1'b1;
    cyc(9);
    chk("both_auto", int'(mode_auto), 1);
    chk("both_count", int'(count), 3);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    cyc(4);

    // reset while holding on 12
    do_reset();
    for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
    chk("pre_hold", int'(count), 11);
    btn_mode = 1'b1;
    n = 0;
    while (!holding && n < 100) begin
      cyc(1);
      n++;
      if (n == 8) btn_mode = 1'b0;
    end
    btn_mode = 1'b0;
    chk("hold_reached", int'(holding), 1);
    chk("hold_count", int'(count), 12);
    rst = 1'b1;
    cyc(1);
    chk("hrst_count", int'(count), 0);
    chk("hrst_hold", int'(holding), 0);
    chk("hrst_auto", int'(mode_auto), 0);
    cyc(1);
    rst = 1'b0;
    btn_mode = 1'b1;
    cyc(8);
    btn_mode = 1'b0;
    n = 0;
    while (count != 5'd1 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("rerun_1", int'(count), 1);
    press(1'b0, 1'b1);

    // randomized activity
    do_reset();
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        cyc($urandom_range(1, 2));
        rst = 1'b0;
      end else begin
        btn_step = 1'($urandom_range(0, 1));
        btn_mode = ($urandom_range(0, 5) == 0);
        cyc($urandom_range(1, 14));
      end
    end

    // reset mid-activity
    btn_mode = 1'b1;
    btn_step = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk("mid_count", int'(count), 0);
    chk("mid_pulse", int'(step_pulse), 0);
    chk("mid_auto", int'(mode_auto), 0);
    chk("mid_hold", int'(holding), 0);
    cyc(1);
    rst = 1'b0;
    btn_mode = 1'b0;
    btn_step = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
